// File: rtl/pcie_ep_pkg.sv
// Shared constants, state encoding and helpers for the PCIe endpoint completer.
package pcie_ep_pkg;

    localparam logic [1:0]  FMT_3DW_NODATA = 2'b00;
    localparam logic [1:0]  FMT_3DW_DATA   = 2'b10;
    localparam logic [4:0]  TYPE_MEM       = 5'b00000;
    localparam logic [9:0]  LEN_ONE_DW     = 10'd1;

    localparam logic [31:0] CPLD_DW0       = 32'h4A00_0001;
    localparam logic [2:0]  CPL_SC         = 3'b000;
    localparam logic [2:0]  CPL_UR         = 3'b001;
    localparam logic [2:0]  CPL_CA         = 3'b100;
    localparam logic [11:0] CPL_BYTE_CNT   = 12'd4;

    typedef enum logic [2:0] {
        RX_HDR  = 3'd0,
        RX_DATA = 3'd1,
        TX_CPL0 = 3'd2,
        TX_CPL1 = 3'd3,
        DISCARD = 3'd4
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pcie_ep_regfile.sv
// Target register array: byte-enable write, combinational read.
module pcie_ep_regfile
    import pcie_ep_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        i_we,
    input  logic [3:0]                  i_be,
    input  logic [$clog2(NUM_REGS)-1:0] i_waddr,
    input  logic [31:0]                 i_wdata,
    input  logic [$clog2(NUM_REGS)-1:0] i_raddr,
    output logic [31:0]                 o_rdata
);

    logic [31:0] r_mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pcie_ep_completer.sv
// PCIe endpoint target: 1-DW MWr32/MRd32 into a small register file,
// CplD generation for reads, discard of everything else.
module pcie_ep_completer
    import pcie_ep_pkg::*;
#(
    parameter logic [15:0] COMPLETER_ID = 16'h0100,
    parameter int          NUM_REGS     = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] m_axis_rx_tdata,
    input  logic [7:0]  m_axis_rx_tkeep,
    input  logic        m_axis_rx_tlast,
    input  logic        m_axis_rx_tvalid,
    output logic        m_axis_rx_tready,
    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    input  logic        s_axis_tx_tready,
    output logic [15:0] drop_count,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    localparam int AW = $clog2(NUM_REGS);

    state_t      r_state;
    state_t      w_next;

    logic        r_is_wr;
    logic [3:0]  r_be;
    logic [15:0] r_reqid;
    logic [7:0]  r_tag;
    logic [31:0] r_rdata;
    logic [6:0]  r_laddr;
    logic [15:0] r_drop;
    logic [15:0] r_wr;
    logic [15:0] r_rd;

    logic        w_rx_rdy;
    logic        w_beat;
    logic [1:0]  w_fmt;
    logic [4:0]  w_type;
    logic [9:0]  w_len;
    logic        w_hdr_ok;
    logic        w_latch_hdr;
    logic        w_wr_en;
    logic        w_rd_cap;
    logic        w_drop;
    logic [AW-1:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_txv;
    logic        w_txl;
    logic [7:0]  w_txk;
    logic [63:0] w_txd;
    logic        w_unused;

    // Ready is decoded from state alone so the handshake never loops
    // back through the next-state logic.
    assign w_rx_rdy = resetn && (r_state == RX_HDR || r_state == RX_DATA ||
                                 r_state == DISCARD);
    assign w_beat   = m_axis_rx_tvalid && w_rx_rdy;

    assign w_fmt    = m_axis_rx_tdata[30:29];
    assign w_type   = m_axis_rx_tdata[28:24];
    assign w_len    = m_axis_rx_tdata[9:0];
    assign w_hdr_ok = (w_fmt == FMT_3DW_DATA || w_fmt == FMT_3DW_NODATA) &&
                      w_type == TYPE_MEM && w_len == LEN_ONE_DW &&
                      !m_axis_rx_tlast;
    assign w_addr   = m_axis_rx_tdata[AW+1:2];

    assign w_unused = ^{m_axis_rx_tkeep, m_axis_rx_tdata[31],
                        m_axis_rx_tdata[23:10]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= RX_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_latch_hdr = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_cap    = 1'b0;
        w_drop      = 1'b0;
        w_txv       = 1'b0;
        w_txl       = 1'b0;
        w_txk       = 8'h00;
        w_txd       = 64'h0;
        unique case (r_state)
            RX_HDR: begin
                if (w_beat) begin
                    if (w_hdr_ok) begin
                        w_latch_hdr = 1'b1;
                        w_next      = RX_DATA;
                    end else begin
                        w_drop = 1'b1;
                        w_next = m_axis_rx_tlast ? RX_HDR : DISCARD;
                    end
                end
            end
            RX_DATA: begin
                if (w_beat) begin
                    if (!m_axis_rx_tlast) begin
                        w_drop = 1'b1;
                        w_next = DISCARD;
                    end else if (r_is_wr) begin
                        w_wr_en = 1'b1;
                        w_next  = RX_HDR;
                    end else begin
                        w_rd_cap = 1'b1;
                        w_next   = TX_CPL0;
                    end
                end
            end
            TX_CPL0: begin
                w_txv = 1'b1;
                w_txk = 8'hFF;
                w_txd = {COMPLETER_ID, CPL_SC, 1'b0, CPL_BYTE_CNT, CPLD_DW0};
                if (s_axis_tx_tready) begin
                    w_next = TX_CPL1;
                end
            end
            TX_CPL1: begin
                w_txv = 1'b1;
                w_txl = 1'b1;
                w_txk = 8'hFF;
                w_txd = {r_rdata, r_reqid, r_tag, 1'b0, r_laddr};
                if (s_axis_tx_tready) begin
                    w_next = RX_HDR;
                end
            end
            DISCARD: begin
                if (w_beat && m_axis_rx_tlast) begin
                    w_next = RX_HDR;
                end
            end
            default: w_next = RX_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_is_wr <= 1'b0;
            r_be    <= '0;
            r_reqid <= '0;
            r_tag   <= '0;
            r_rdata <= '0;
            r_laddr <= '0;
            r_drop  <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            if (w_latch_hdr) begin
                r_is_wr <= (w_fmt == FMT_3DW_DATA);
                r_be    <= m_axis_rx_tdata[35:32];
                r_reqid <= m_axis_rx_tdata[63:48];
                r_tag   <= m_axis_rx_tdata[47:40];
            end
            if (w_rd_cap) begin
                r_rdata <= w_rdata;
                r_laddr <= m_axis_rx_tdata[6:0];
                r_rd    <= r_rd + 16'd1;
            end
            if (w_wr_en) begin
                r_wr <= r_wr + 16'd1;
            end
            if (w_drop) begin
                r_drop <= sat_inc16(r_drop);
            end
        end
    end

    pcie_ep_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .resetn  (resetn),
        .i_we    (w_wr_en),
        .i_be    (r_be),
        .i_waddr (w_addr),
        .i_wdata (m_axis_rx_tdata[63:32]),
        .i_raddr (w_addr),
        .o_rdata (w_rdata)
    );

    assign m_axis_rx_tready = w_rx_rdy;
    assign s_axis_tx_tvalid = w_txv;
    assign s_axis_tx_tlast  = w_txl;
    assign s_axis_tx_tkeep  = w_txk;
    assign s_axis_tx_tdata  = w_txd;
    assign drop_count       = r_drop;
    assign wr_count         = r_wr;
    assign rd_count         = r_rd;

endmodule

// File: tb/tb_pcie_ep_completer.sv
// Randomized bench for pcie_ep_completer against a transaction-level
// model of the register file, counters and expected completions.
module tb_pcie_ep_completer;

    localparam int NREG = 16;

    localparam int K_WR      = 0;
    localparam int K_RD      = 1;
    localparam int K_RDLEN2  = 2;
    localparam int K_WR4DW   = 3;
    localparam int K_HDRLAST = 4;
    localparam int K_NOLAST  = 5;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [63:0] m_axis_rx_tdata = '0;
    logic [7:0]  m_axis_rx_tkeep = '0;
    logic        m_axis_rx_tlast = 1'b0;
    logic        m_axis_rx_tvalid = 1'b0;
    logic        m_axis_rx_tready;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tvalid;
    logic        s_axis_tx_tready;
    logic [15:0] drop_count;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    always #5 clk = ~clk;

    pcie_ep_completer #(
        .COMPLETER_ID (16'h0100),
        .NUM_REGS     (NREG)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .m_axis_rx_tdata  (m_axis_rx_tdata),
        .m_axis_rx_tkeep  (m_axis_rx_tkeep),
        .m_axis_rx_tlast  (m_axis_rx_tlast),
        .m_axis_rx_tvalid (m_axis_rx_tvalid),
        .m_axis_rx_tready (m_axis_rx_tready),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tready (s_axis_tx_tready),
        .drop_count       (drop_count),
        .wr_count         (wr_count),
        .rd_count         (rd_count)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } rxb_t;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } txb_t;

    rxb_t        rx_q[$];
    txb_t        exp_q[$];
    logic [31:0] m_regs [NREG];
    logic [15:0] m_drop = '0;
    logic [15:0] m_wr = '0;
    logic [15:0] m_rd = '0;

    int   tx_mode = 2;
    logic tx_manual = 1'b0;
    logic rnd_rdy = 1'b1;

    assign s_axis_tx_tready = (tx_mode == 0) ? rnd_rdy :
                              (tx_mode == 2) ? 1'b1 : tx_manual;

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    logic        hold_pend = 1'b0;
    logic [63:0] hold_d = '0;

    always @(negedge clk) begin
        txb_t e;
        if (!resetn) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check_eq("tx_hold_valid", 64'(s_axis_tx_tvalid), 64'd1);
                check_eq("tx_hold_data", s_axis_tx_tdata, hold_d);
            end
            hold_pend = 1'b0;
            if (s_axis_tx_tvalid) begin
                if (s_axis_tx_tready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("tx_unexpected", 64'(s_axis_tx_tvalid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("tx_data", s_axis_tx_tdata, e.d);
                        check_eq("tx_last", 64'(s_axis_tx_tlast), 64'(e.l));
                        check_eq("tx_keep", 64'(s_axis_tx_tkeep), 64'hFF);
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_d    = s_axis_tx_tdata;
                end
            end
        end
    end

    task automatic push_rx(input logic [63:0] d, input logic [7:0] k,
                           input logic l);
        rxb_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        rx_q.push_back(b);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_drop = '0;
        m_wr   = '0;
        m_rd   = '0;
    endtask

    task automatic model_drop();
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    endtask

    task automatic build_tlp(input int kind, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] data,
                             input logic [15:0] rid, input logic [7:0] tag);
        logic [31:0] dw1;
        int          idx;
        txb_t        t;
        dw1 = {rid, tag, 4'h0, be};
        idx = int'((addr >> 2) % NREG);
        case (kind)
            K_WR: begin
                push_rx({dw1, 32'h4000_0001}, 8'hFF, 1'b0);
                push_rx({data, addr}, 8'hFF, 1'b1);
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
                m_wr = m_wr + 16'd1;
            end
            K_RD: begin
                push_rx({dw1, 32'h0000_0001}, 8'hFF, 1'b0);
                push_rx({data, addr}, 8'h0F, 1'b1);
                t.d = {16'h0100, 16'h0004, 32'h4A00_0001};
                t.l = 1'b0;
                exp_q.push_back(t);
                t.d = {m_regs[idx], rid, tag, 1'b0, addr[6:0]};
                t.l = 1'b1;
                exp_q.push_back(t);
                m_rd = m_rd + 16'd1;
            end
            K_RDLEN2: begin
                push_rx({dw1, 32'h0000_0002}, 8'hFF, 1'b0);
                push_rx({data, addr}, 8'hFF, 1'b1);
                model_drop();
            end
            K_WR4DW: begin
                push_rx({dw1, 32'h6000_0001}, 8'hFF, 1'b0);
                push_rx({addr, 32'h0}, 8'hFF, 1'b0);
                push_rx({32'h0, data}, 8'h0F, 1'b1);
                model_drop();
            end
            K_HDRLAST: begin
                push_rx({dw1, 32'h4000_0001}, 8'hFF, 1'b1);
                model_drop();
            end
            default: begin
                push_rx({dw1, 32'h4000_0001}, 8'hFF, 1'b0);
                push_rx({data, addr}, 8'hFF, 1'b0);
                push_rx({~data, addr}, 8'hFF, 1'b1);
                model_drop();
            end
        endcase
    endtask

    task automatic send_rx();
        rxb_t b;
        logic ok;
        int   w;
        while (rx_q.size() > 0) begin
            b = rx_q.pop_front();
            if ($urandom_range(0, 3) == 0) begin
                m_axis_rx_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            m_axis_rx_tvalid = 1'b1;
            m_axis_rx_tdata  = b.d;
            m_axis_rx_tkeep  = b.k;
            m_axis_rx_tlast  = b.l;
            ok = 1'b0;
            w  = 0;
            while (!ok && w < 200) begin
                @(negedge clk);
                ok = m_axis_rx_tready;
                w++;
            end
            @(posedge clk);
            #1;
            if (!ok) begin
                check_eq("rx_ready_timeout", 64'(ok), 64'd1);
                rx_q.delete();
            end
        end
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tlast  = 1'b0;
        m_axis_rx_tkeep  = '0;
        m_axis_rx_tdata  = '0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (w < 300) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !s_axis_tx_tvalid) break;
            w++;
        end
        check_eq("tx_drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts();
        check_eq("drop_count", 64'(drop_count), 64'(m_drop));
        check_eq("wr_count", 64'(wr_count), 64'(m_wr));
        check_eq("rd_count", 64'(rd_count), 64'(m_rd));
    endtask

    task automatic do_tlp(input int kind, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data,
                          input logic [15:0] rid, input logic [7:0] tag);
        build_tlp(kind, addr, be, data, rid, tag);
        send_rx();
        wait_idle();
        check_counts();
    endtask

    initial begin
        int k;
        model_reset();

        resetn  = 1'b0;
        tx_mode = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
        check_eq("rst_tlast", 64'(s_axis_tx_tlast), 64'd0);
        check_eq("rst_tkeep", 64'(s_axis_tx_tkeep), 64'd0);
        check_eq("rst_tdata", s_axis_tx_tdata, 64'd0);
        check_eq("rst_rx_tready", 64'(m_axis_rx_tready), 64'd0);
        check_counts();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rx_tready", 64'(m_axis_rx_tready), 64'd1);
        @(posedge clk);
        #1;

        do_tlp(K_WR, 32'h8, 4'hF, 32'h1234_5678, 16'h0000, 8'h00);
        do_tlp(K_RD, 32'h8, 4'hF, 32'h0, 16'hABCD, 8'h05);

        tx_mode   = 1;
        tx_manual = 1'b0;
        build_tlp(K_RD, 32'h8, 4'hF, 32'h0, 16'h1111, 8'h22);
        send_rx();
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_tvalid", 64'(s_axis_tx_tvalid), 64'd1);
            check_eq("bp_beat0", s_axis_tx_tdata, 64'h0100_0004_4A00_0001);
            check_eq("bp_rx_tready", 64'(m_axis_rx_tready), 64'd0);
        end
        tx_mode = 2;
        wait_idle();
        check_counts();

        do_tlp(K_WR, 32'h8, 4'h3, 32'hFFFF_FFFF, 16'h0, 8'h0);
        do_tlp(K_RD, 32'h8, 4'hF, 32'h0, 16'h0102, 8'h03);

        do_tlp(K_RDLEN2, 32'h8, 4'hF, 32'hDEAD_BEEF, 16'h0, 8'h0);
        do_tlp(K_WR4DW, 32'h8, 4'hF, 32'hDEAD_BEEF, 16'h0, 8'h0);
        do_tlp(K_HDRLAST, 32'h8, 4'hF, 32'hDEAD_BEEF, 16'h0, 8'h0);
        do_tlp(K_NOLAST, 32'h8, 4'hF, 32'hDEAD_BEEF, 16'h0, 8'h0);
        do_tlp(K_RD, 32'h8, 4'hF, 32'h0, 16'h0405, 8'h06);

        tx_mode = 0;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 9);
            if (k < 4)      k = K_WR;
            else if (k < 8) k = K_RD;
            else            k = $urandom_range(2, 5);
            do_tlp(k, $urandom, 4'($urandom), $urandom,
                   16'($urandom), 8'($urandom));
        end
        for (int i = 0; i < NREG; i++) begin
            do_tlp(K_RD, 32'(i * 4) | 32'hFFFF_0000, 4'hF, 32'h0,
                   16'($urandom), 8'(i));
        end

        tx_mode   = 1;
        tx_manual = 1'b0;
        build_tlp(K_RD, 32'h8, 4'hF, 32'h0, 16'h7777, 8'h01);
        send_rx();
        tx_manual = 1'b1;
        @(posedge clk);
        #1;
        tx_manual = 1'b0;
        @(negedge clk);
        check_eq("cpl1_pending", 64'(s_axis_tx_tvalid), 64'd1);
        check_eq("cpl1_last", 64'(s_axis_tx_tlast), 64'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_mid_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
        check_counts();
        resetn  = 1'b1;
        tx_mode = 2;
        @(posedge clk);
        #1;
        do_tlp(K_RD, 32'h8, 4'hF, 32'h0, 16'hABCD, 8'h05);
        do_tlp(K_RD, 32'h4, 4'hF, 32'h0, 16'hABCD, 8'h06);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pcie_ep_completer.md
PCIE_EP_COMPLETER -- requirements
Module: pcie_ep_completer

Interface
REQ-001 Parameter: COMPLETER_ID, 16'h0100, bus/dev/fn placed in CplD DW1[31:16].
REQ-002 Parameter: NUM_REGS, 16, number of 32-bit target registers (power of two, 2..64).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 m_axis_rx_tdata  in  64  request TLP beats: beat0 {DW1,DW0}, beat1 {DATA,DW2}.
REQ-006 m_axis_rx_tkeep  in  8  byte enables; 8'h0F on MRd beat1.
REQ-007 m_axis_rx_tlast / m_axis_rx_tvalid  in  1 each  last beat / beat valid.
REQ-008 m_axis_rx_tready  out  1  request accept.
REQ-009 s_axis_tx_tdata  out  64  completion TLP beats.
REQ-010 s_axis_tx_tkeep  out  8; s_axis_tx_tlast, s_axis_tx_tvalid  out  1 each; s_axis_tx_tready  in  1.
REQ-011 drop_count  out  16  count of discarded TLPs, saturating.
REQ-012 wr_count / rd_count  out  16 each  accepted MWr / MRd counts, wrapping.

Function
REQ-013 A beat transfers when tvalid and tready are both high; no other beat counts.
REQ-014 States: RX_HDR, RX_DATA, TX_CPL0, TX_CPL1, DISCARD.
REQ-015 RX_HDR: tready=1; decode beat0 DW0 fmt[30:29], type[28:24], length[9:0]; latch DW0, DW1.
REQ-016 Supported requests: MWr32 (fmt 10, type 00000, length 1) and MRd32 (fmt 00, type 00000, length 1); go to RX_DATA.
REQ-017 Any other beat0, including a beat0 with tlast=1, increments drop_count; go to DISCARD, or stay in RX_HDR if tlast=1.
REQ-018 DISCARD: tready=1; consume beats until a beat with tlast=1; then go to RX_HDR.
REQ-019 RX_DATA, MWr: on beat1 write DATA into reg[DW2[k+1:2]], k=log2(NUM_REGS), per first-DW BE DW1[3:0]; upper address bits are ignored (aliasing).
REQ-020 RX_DATA, MWr: write commits on the beat1 clock edge; increment wr_count; go to RX_HDR. No completion is sent.
REQ-021 RX_DATA, MRd: on beat1 latch the register word, requester ID DW1[31:16], tag DW1[15:8] and DW2[6:0]; increment rd_count; go to TX_CPL0.
REQ-022 RX_DATA, beat1 without tlast: treat as malformed; no write, no read; increment drop_count; go to DISCARD.
REQ-023 m_axis_rx_tready=0 in TX_CPL0 and TX_CPL1; at most one completion is outstanding.
REQ-024 TX_CPL0: tvalid=1, tlast=0, tkeep=FF, tdata[31:0] = DW0 (4A000001: fmt 10, type 01010, TC/attr 0, length 1).
REQ-025 TX_CPL0: tdata[63:32] = {COMPLETER_ID, status 000, BCM 0, byte count 12'd4}.
REQ-026 TX_CPL1: tvalid=1, tlast=1, tkeep=FF, tdata = {read data, requester ID, tag, 1'b0, lower address[6:0]}.
REQ-027 TX_CPL0 advances to TX_CPL1 and TX_CPL1 advances to RX_HDR only on a cycle with s_axis_tx_tready=1.
REQ-028 While tready=0, tdata, tkeep and tlast hold stable with tvalid=1.
REQ-029 Latency: CplD beat0 is valid the cycle after MRd beat1 is accepted; the next request can be accepted the cycle after CplD beat1 transfers.
REQ-030 Reads return the value before any write of the same request; with one outstanding request, no read/write hazard exists.
REQ-031 Counters: drop_count saturates at FFFF; wr_count and rd_count wrap to 0.

Reset
REQ-032 On resetn=0 at a clock edge: state=RX_HDR, s_axis_tx_tvalid=0, tlast=0, tkeep=0, tdata=0.
REQ-033 On resetn=0: all registers=0, all counters=0; m_axis_rx_tready=0 during reset, 1 on the first cycle after.
REQ-034 Reset mid-TLP (RX or TX) abandons the packet; no partial write persists beyond what committed under REQ-020.

Structure
REQ-035 A shared package holds fmt/type constants, CplD DW0 constant, status codes, and state encoding.
REQ-036 One sub-module, pcie_ep_regfile: NUM_REGS x 32 registers, byte-enable write, combinational read.

Verification
REQ-037 MWr 40000001/0000000F/00000008 data 12345678 -> reg[2]=12345678, no TX beat, wr_count=1.
REQ-038 MRd 00000001/ABCD050F/00000008 -> TX beats {01000004,4A000001}, {12345678,ABCD0508}, tlast on beat2.
REQ-039 MRd with tx_tready low 5 cycles in TX_CPL0 -> beat0 held stable, rx_tready=0, then completes in order.
REQ-040 MWr BE 0x3 data FFFFFFFF onto reg=12345678 -> reg=1234FFFF.
REQ-041 MRd length 2, then 4DW MWr of 3 beats -> drop_count=2, beats consumed to tlast, no TX, registers unchanged.
REQ-042 resetn low during TX_CPL1 -> tvalid=0 next cycle, registers/counters 0, next MRd completes normally.
